// File: rtl/modarith_pkg.sv
// Shared definitions for the modular add/subtract sequencer.
//   WIDTH_DEF : default operand width of the mpadder interface
//   state_t   : sequencer FSM states
//   OP_ADD / OP_SUB : op-select encodings (host 'subtract' and adder 'add_subtract')
package modarith_pkg;

    localparam int unsigned WIDTH_DEF = 514;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE1,
        WAIT1,
        ISSUE2,
        WAIT2,
        FIN
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_seq.sv
// Modular add/subtract sequencer driving an external (shared) mpadder.
// Computes (a+b) mod m or (a-b) mod m with one or two adder operations plus
// the conditional correction.
//
// Optional build macro: MODADD_CONST_TIME_EN
//   defined   -> subtract always issues the correction op (data-independent timing)
//   undefined -> subtract skips the correction op when a >= b
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, subtract       : host request pulse and op select (captured in IDLE)
//   in_a, in_b, in_m      : operands and modulus (a,b < m < 2^(WIDTH-1))
//   result, done, busy    : modular result, one-cycle completion pulse, busy flag
//   add_start, add_subtract, add_in_a, add_in_b : request side of the mpadder
//   add_result, add_done  : mpadder response (bit WIDTH = borrow on subtract)
module mod_addsub_seq
    import modarith_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
);

`ifdef MODADD_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic             op_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] r1_q;
    logic             borrow_q;
    logic             need_op2;

    // Add always needs the trial subtraction of m; subtract needs the +m
    // correction only when op1 borrowed (or always, in constant-time builds).
    always_comb begin
        need_op2 = (op_q == OP_ADD) || add_result[WIDTH] || CONST_TIME;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        add_start  = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = ISSUE1;
            end
            ISSUE1: begin
                add_start  = 1'b1;
                state_next = WAIT1;
            end
            WAIT1: begin
                if (add_done) state_next = need_op2 ? ISSUE2 : FIN;
            end
            ISSUE2: begin
                add_start  = 1'b1;
                state_next = WAIT2;
            end
            WAIT2: begin
                if (add_done) state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= '0;
            add_subtract <= OP_ADD;
            add_in_a     <= '0;
            add_in_b     <= '0;
            op_q         <= OP_ADD;
            m_q          <= '0;
            r1_q         <= '0;
            borrow_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q         <= subtract;
                        m_q          <= in_m;
                        add_in_a     <= in_a;
                        add_in_b     <= in_b;
                        add_subtract <= subtract;
                    end
                end
                WAIT1: begin
                    if (add_done) begin
                        r1_q     <= add_result[WIDTH-1:0];
                        borrow_q <= add_result[WIDTH];
                        if (need_op2) begin
                            add_in_a     <= add_result[WIDTH-1:0];
                            add_in_b     <= m_q;
                            add_subtract <= (op_q == OP_ADD) ? OP_SUB : OP_ADD;
                        end else begin
                            result <= add_result[WIDTH-1:0];
                        end
                    end
                end
                WAIT2: begin
                    if (add_done) begin
                        if (op_q == OP_ADD) begin
                            // r1 - m borrowed -> r1 was already reduced
                            result <= add_result[WIDTH] ? r1_q : add_result[WIDTH-1:0];
                        end else begin
                            // correction is only kept when op1 actually borrowed
                            result <= borrow_q ? add_result[WIDTH-1:0] : r1_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Directed self-checking bench for mod_addsub_seq with a behavioural mpadder
// of programmable latency L. Honours MODADD_CONST_TIME_EN like the design.
module tb_mod_addsub_seq;

    localparam int unsigned WIDTH = 514;
    localparam int unsigned L     = 3;
    localparam int ONE_OP = L + 2;      // negedges from start to done, one adder op
    localparam int TWO_OP = 2 * L + 3;  // two adder ops

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a, in_b, in_m;
    logic [WIDTH-1:0] result;
    logic             done, busy;
    logic             add_start, add_subtract;
    logic [WIDTH-1:0] add_in_a, add_in_b;
    logic [WIDTH:0]   add_result;
    logic             add_done;

    logic             model_pending = 1'b0;
    int               model_cnt = 0;
    logic             force_done;
    int               start_cnt = 0;
    int               done_cnt = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mod_addsub_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .subtract(subtract),
        .in_a(in_a),
        .in_b(in_b),
        .in_m(in_m),
        .result(result),
        .done(done),
        .busy(busy),
        .add_start(add_start),
        .add_subtract(add_subtract),
        .add_in_a(add_in_a),
        .add_in_b(add_in_b),
        .add_result(add_result),
        .add_done(add_done)
    );

    // Behavioural mpadder: add_done is high L cycles after the add_start cycle.
    always @(posedge clk) begin
        if (add_start) begin
            add_result    <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                          : ({1'b0, add_in_a} + {1'b0, add_in_b});
            model_cnt     <= L - 1;
            model_pending <= 1'b1;
        end else if (model_pending) begin
            if (model_cnt == 0) model_pending <= 1'b0;
            else model_cnt <= model_cnt - 1;
        end
        if (add_start) start_cnt <= start_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    assign add_done = (model_pending && model_cnt == 0) || force_done;

    task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] m, input logic sub, input logic [WIDTH-1:0] exp_res,
                          input int exp_starts, input int exp_cycles, input bit glitch);
        int s0, d0, n;
        bit got;
        s0 = start_cnt;
        d0 = done_cnt;
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            // scramble host inputs: the design must use captured values
            start = 1'b0;
            in_a = '1; in_b = '1; in_m = '1; subtract = ~sub;
            if (glitch && n == 6) start = 1'b1;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, " done_seen"}, got, 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " cycles"}, n, exp_cycles);
        check({tag, " add_starts"}, start_cnt - s0, exp_starts);
        @(negedge clk);
        check({tag, " done_width"}, done, 0);
        check({tag, " busy_after"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, " done_count"}, done_cnt - d0, 1);
        check({tag, " result_held"}, result, exp_res);
    endtask

    initial begin
        logic [WIDTH-1:0] bm;
        int d0, busy_seen;

        reset = 1'b1; start = 1'b0; subtract = 1'b0; force_done = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (2) @(negedge clk);
        check("rst result", result, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        check("rst add_start", add_start, 0);
        check("rst add_subtract", add_subtract, 0);
        check("rst add_in_a", add_in_a, 0);
        check("rst add_in_b", add_in_b, 0);
        reset = 1'b0;

        run_op("add7+9", 7, 9, 13, 1'b0, 3, 2, TWO_OP, 1'b0);
        run_op("add3+4", 3, 4, 13, 1'b0, 7, 2, TWO_OP, 1'b0);
        run_op("sub4-9", 4, 9, 13, 1'b1, 8, 2, TWO_OP, 1'b0);
`ifdef MODADD_CONST_TIME_EN
        run_op("sub9-4", 9, 4, 13, 1'b1, 5, 2, TWO_OP, 1'b0);
`else
        run_op("sub9-4", 9, 4, 13, 1'b1, 5, 1, ONE_OP, 1'b0);
`endif

        bm = '0;
        bm[512] = 1'b1;
        bm = bm - 569;
        run_op("big add", bm - 1, bm - 1, bm, 1'b0, bm - 2, 2, TWO_OP, 1'b0);
        run_op("big sub", 0, bm - 1, bm, 1'b1, 1, 2, TWO_OP, 1'b0);

        // Reset during WAIT1; the adder's late add_done lands after reset.
        d0 = done_cnt;
        @(negedge clk);
        in_a = 7; in_b = 9; in_m = 13; subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy", busy, 0);
        check("midrst add_start", add_start, 0);
        check("midrst result", result, 0);
        check("midrst add_in_a", add_in_a, 0);
        check("midrst add_in_b", add_in_b, 0);
        check("midrst add_subtract", add_subtract, 0);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("midrst no_done", done_cnt - d0, 0);
        check("midrst stays idle", busy_seen, 0);
        run_op("post-rst add1+1", 1, 1, 13, 1'b0, 2, 2, TWO_OP, 1'b0);

        // Second start during WAIT2 must be ignored.
        run_op("restart-in-wait2", 7, 9, 13, 1'b0, 3, 2, TWO_OP, 1'b1);

        // add_done forced while idle.
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        check("idle add_done busy", busy, 0);
        check("idle add_done add_start", add_start, 0);
        @(negedge clk);
        check("idle add_done done", done, 0);
        check("idle add_done busy2", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
